// File: rtl/csc_pkg.sv
// csc_pkg: mode encodings, x256 coefficient and offset tables, saturation.
// Optional macro CSC_CLAMP_EN (used by csc_row) enables studio-range clamping.
package csc_pkg;

  typedef enum logic [1:0] {
    CSC_RGB2YUV601 = 2'd0,
    CSC_RGB2YUV709 = 2'd1,
    CSC_YUV2RGB601 = 2'd2,
    CSC_BYPASS     = 2'd3
  } csc_mode_e;

  localparam int CSC_DW_MAX = 12;

  // [mode][row][col], x256 fixed point
  localparam int CSC_COEF [4][3][3] = '{
    '{'{66, 129, 25}, '{-38, -74, 112}, '{112, -94, -18}},
    '{'{47, 157, 16}, '{-26, -87, 112}, '{112, -102, -10}},
    '{'{298, 0, 409}, '{298, -100, -208}, '{298, 516, 0}},
    '{'{256, 0, 0}, '{0, 256, 0}, '{0, 0, 256}}
  };

  // [mode][row], x256 units at DW=8; the inverse rows fold the
  // -16/-128/-128 input pre-offsets through the coefficients
  localparam int CSC_OFF [4][3] = '{
    '{4096, 32768, 32768},
    '{4096, 32768, 32768},
    '{-57120, 34656, -70816},
    '{0, 0, 0}
  };

  function automatic logic [CSC_DW_MAX-1:0] sat_u(
    input logic signed [31:0] v,
    input int                 dw
  );
    logic signed [31:0] hi;
    hi = (32'sd1 <<< dw) - 32'sd1;
    if (v < 0) return '0;
    if (v > hi) return hi[CSC_DW_MAX-1:0];
    return v[CSC_DW_MAX-1:0];
  endfunction

endpackage

// File: rtl/csc_row.sv
// csc_row: one output component: 3 multipliers, adder, round and saturate.
// CSC_CLAMP_EN adds studio-range clamping in the RGB->YCbCr modes.
module csc_row
  import csc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CW  = 11,
  parameter int ROW = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] c0_i,
  input  logic [DW-1:0] c1_i,
  input  logic [DW-1:0] c2_i,
  output logic [DW-1:0] y_o
);

  localparam int PW = DW + CW + 1;
  localparam int AW = DW + CW + 2;
  localparam int SC = 1 << (DW - 8);

  logic [DW-1:0]        c [3];
  logic signed [PW-1:0] p_d [3];
  logic signed [PW-1:0] p_q [3];
  logic signed [AW-1:0] off_d, off_q;
  logic signed [AW-1:0] acc_d, acc_q;
  logic [DW-1:0]        y_d, y_q;

  assign c[0] = c0_i;
  assign c[1] = c1_i;
  assign c[2] = c2_i;
  assign y_o  = y_q;

`ifdef CSC_CLAMP_EN
  localparam logic [DW-1:0] CLO = DW'(16 * SC);
  localparam logic [DW-1:0] CHI = DW'((ROW == 0 ? 235 : 240) * SC);

  logic [1:0] mode_s1_d, mode_s1_q;
  logic [1:0] mode_s2_d, mode_s2_q;

  // Mode follows the pixel so the clamp decision matches its data
  always_comb begin
    mode_s1_d = mode_i;
    mode_s2_d = mode_s1_q;
  end

  // Mode delay registers for the clamp stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
    end else begin
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
    end
  end
`endif

  // Stage 1: products (inputs zero-extended) and row offset with rounding
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      p_d[k] = PW'($signed({1'b0, c[k]}))
             * PW'($signed(CW'(CSC_COEF[mode_i][ROW][k])));
    end
    off_d = AW'(CSC_OFF[mode_i][ROW] * SC + 128);
  end

  // Stage 2: row sum
  always_comb begin
    acc_d = AW'(p_q[0]) + AW'(p_q[1]) + AW'(p_q[2]) + off_q;
  end

  // Stage 3: drop the x256 scale, saturate, optionally clamp
  always_comb begin
    y_d = DW'(sat_u(32'(acc_q >>> 8), DW));
`ifdef CSC_CLAMP_EN
    if (mode_s2_q == CSC_RGB2YUV601 || mode_s2_q == CSC_RGB2YUV709) begin
      if (y_d < CLO) y_d = CLO;
      else if (y_d > CHI) y_d = CHI;
    end
`endif
  end

  // Datapath registers for all three stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) p_q[k] <= '0;
      off_q <= '0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      for (int k = 0; k < 3; k++) p_q[k] <= p_d[k];
      off_q <= off_d;
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/csc_pipe.sv
// csc_pipe: colour-space converter top: mode commit, sync delay, pixel count.
// Build with CSC_CLAMP_EN defined for studio-range clamping of YCbCr output.
module csc_pipe
  import csc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CW  = 11,
  parameter int LAT = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    mode_i,
  input  logic          vs_i,
  input  logic          hs_i,
  input  logic          de_i,
  input  logic [DW-1:0] c0_i,
  input  logic [DW-1:0] c1_i,
  input  logic [DW-1:0] c2_i,
  output logic          vs_o,
  output logic          hs_o,
  output logic          de_o,
  output logic [DW-1:0] c0_o,
  output logic [DW-1:0] c1_o,
  output logic [DW-1:0] c2_o,
  output logic [1:0]    mode_o,
  output logic [23:0]   pix_cnt_o
);

  logic             vs_prev_d, vs_prev_q;
  logic [1:0]       mode_act_d, mode_act_q;
  logic [1:0]       mode_eff;
  logic [LAT-1:0]   vs_dl_d, vs_dl_q;
  logic [LAT-1:0]   hs_dl_d, hs_dl_q;
  logic [LAT-1:0]   de_dl_d, de_dl_q;
  logic [1:0]       mode_dl_d [LAT];
  logic [1:0]       mode_dl_q [LAT];
  logic             vso_prev_d, vso_prev_q;
  logic [23:0]      cnt_d, cnt_q;
  logic [23:0]      pix_d, pix_q;
  logic [DW-1:0]    y0, y1, y2;

  // Commit mode on the vs rise; that frame-start pixel already uses it
  always_comb begin
    mode_eff   = (vs_i && !vs_prev_q) ? mode_i : mode_act_q;
    mode_act_d = mode_eff;
    vs_prev_d  = vs_i;
  end

  // Sync and mode delay lines matched to the datapath depth
  always_comb begin
    vs_dl_d      = {vs_dl_q[LAT-2:0], vs_i};
    hs_dl_d      = {hs_dl_q[LAT-2:0], hs_i};
    de_dl_d      = {de_dl_q[LAT-2:0], de_i};
    mode_dl_d[0] = mode_eff;
    for (int i = 1; i < LAT; i++) mode_dl_d[i] = mode_dl_q[i-1];
  end

  // Saturating de_o counter, published and restarted on the vs_o rise
  always_comb begin
    vso_prev_d = vs_o;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    if (vs_o && !vso_prev_q) begin
      pix_d = cnt_q;
      cnt_d = {23'd0, de_o};
    end else if (de_o && cnt_q != '1) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_prev_q  <= 1'b0;
      mode_act_q <= '0;
      vs_dl_q    <= '0;
      hs_dl_q    <= '0;
      de_dl_q    <= '0;
      for (int i = 0; i < LAT; i++) mode_dl_q[i] <= '0;
      vso_prev_q <= 1'b0;
      cnt_q      <= '0;
      pix_q      <= '0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      mode_act_q <= mode_act_d;
      vs_dl_q    <= vs_dl_d;
      hs_dl_q    <= hs_dl_d;
      de_dl_q    <= de_dl_d;
      for (int i = 0; i < LAT; i++) mode_dl_q[i] <= mode_dl_d[i];
      vso_prev_q <= vso_prev_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
    end
  end

  csc_row #(.DW(DW), .CW(CW), .ROW(0)) u_row0 (
    .clk_i (clk_i), .rst_i (rst_i), .mode_i (mode_eff),
    .c0_i (c0_i), .c1_i (c1_i), .c2_i (c2_i), .y_o (y0)
  );

  csc_row #(.DW(DW), .CW(CW), .ROW(1)) u_row1 (
    .clk_i (clk_i), .rst_i (rst_i), .mode_i (mode_eff),
    .c0_i (c0_i), .c1_i (c1_i), .c2_i (c2_i), .y_o (y1)
  );

  csc_row #(.DW(DW), .CW(CW), .ROW(2)) u_row2 (
    .clk_i (clk_i), .rst_i (rst_i), .mode_i (mode_eff),
    .c0_i (c0_i), .c1_i (c1_i), .c2_i (c2_i), .y_o (y2)
  );

  assign vs_o      = vs_dl_q[LAT-1];
  assign hs_o      = hs_dl_q[LAT-1];
  assign de_o      = de_dl_q[LAT-1];
  assign mode_o    = mode_dl_q[LAT-1];
  assign pix_cnt_o = pix_q;
  assign c0_o      = de_o ? y0 : '0;
  assign c1_o      = de_o ? y1 : '0;
  assign c2_o      = de_o ? y2 : '0;

endmodule
